// File: rtl/cache_memory_dm.sv
// Direct-mapped, write-through, no-write-allocate cache with a one-cycle hit path.
// Arrays are read with the current-cycle address and compared against the registered request.
module cache_memory_dm #(
    parameter  int FE_ADDR_W  = 32,
    parameter  int FE_DATA_W  = 32,
    parameter  int NLINES_W   = 4,
    parameter  int WORD_OFF_W = 2,
    localparam int FE_NBYTES  = FE_DATA_W / 8,
    localparam int FE_BYTE_W  = $clog2(FE_NBYTES),
    localparam int WADDR_W    = FE_ADDR_W - FE_BYTE_W,
    localparam int LADDR_W    = WADDR_W - WORD_OFF_W,
    localparam int TAG_W      = FE_ADDR_W - FE_BYTE_W - WORD_OFF_W - NLINES_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 data_valid,
    input  logic [WADDR_W-1:0]   data_addr,
    input  logic                 data_valid_reg,
    input  logic [WADDR_W-1:0]   data_addr_reg,
    input  logic [FE_DATA_W-1:0] data_wdata_reg,
    input  logic [FE_NBYTES-1:0] data_wstrb_reg,
    output logic [FE_DATA_W-1:0] data_rdata,
    output logic                 data_ready,
    input  logic                 invalidate,
    output logic                 read_valid,
    output logic [LADDR_W-1:0]   read_addr,
    input  logic [FE_DATA_W-1:0] read_rdata,
    input  logic                 read_ready,
    output logic                 write_valid,
    output logic [WADDR_W-1:0]   write_addr,
    output logic [FE_DATA_W-1:0] write_wdata,
    output logic [FE_NBYTES-1:0] write_wstrb,
    input  logic                 write_ready
);

    localparam int NLINES = 1 << NLINES_W;
    localparam int NWORDS = 1 << WORD_OFF_W;

    typedef enum logic [1:0] {IDLE, REFILL, REPLAY, WRITE} state_t;

    state_t state, next_state;

    logic [WORD_OFF_W-1:0] word_cnt;
    logic [NLINES-1:0]     valid_bits;
    logic                  write_hit;

    logic [TAG_W-1:0]      tag_mem  [NLINES];
    logic [FE_DATA_W-1:0]  data_mem [NLINES*NWORDS];

    logic                  rd_valid;
    logic [TAG_W-1:0]      rd_tag;
    logic [FE_DATA_W-1:0]  rd_data;

    logic                  rd_en;
    logic [WADDR_W-1:0]    rd_addr;
    logic [NLINES_W-1:0]   rd_idx;
    logic [WORD_OFF_W-1:0] rd_off;

    logic [TAG_W-1:0]      req_tag;
    logic [NLINES_W-1:0]   req_idx;
    logic [WORD_OFF_W-1:0] req_off;

    logic hit;
    logic refill_we;
    logic refill_last;
    logic write_upd;
    logic ready_int;

    // REPLAY re-reads the held request; IDLE looks ahead at the incoming one.
    assign rd_en   = (state == IDLE && data_valid) || (state == REPLAY);
    assign rd_addr = (state == REPLAY) ? data_addr_reg : data_addr;
    assign rd_idx  = rd_addr[WORD_OFF_W +: NLINES_W];
    assign rd_off  = rd_addr[WORD_OFF_W-1:0];

    assign req_tag = data_addr_reg[WADDR_W-1 -: TAG_W];
    assign req_idx = data_addr_reg[WORD_OFF_W +: NLINES_W];
    assign req_off = data_addr_reg[WORD_OFF_W-1:0];

    assign hit         = rd_valid && (rd_tag == req_tag);
    assign refill_we   = (state == REFILL) && read_ready && reset;
    assign refill_last = refill_we && (&word_cnt);
    assign write_upd   = (state == WRITE) && write_ready && write_hit && reset;

    // NOTE: tag and data arrays carry no reset; only valid bits define line contents,
    // which keeps these arrays mappable onto plain RAM.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_tag  <= tag_mem[rd_idx];
            rd_data <= data_mem[{rd_idx, rd_off}];
        end
        if (refill_we) begin
            data_mem[{req_idx, word_cnt}] <= read_rdata;
        end
        if (refill_last) begin
            tag_mem[req_idx] <= req_tag;
        end
        if (write_upd) begin
            for (int b = 0; b < FE_NBYTES; b++) begin
                if (data_wstrb_reg[b]) begin
                    data_mem[{req_idx, req_off}][8*b +: 8] <= data_wdata_reg[8*b +: 8];
                end
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            valid_bits <= '0;
            word_cnt   <= '0;
            write_hit  <= 1'b0;
            rd_valid   <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE && data_valid_reg) begin
                write_hit <= hit;
            end
            if (refill_we) begin
                word_cnt <= word_cnt + WORD_OFF_W'(1);
            end
            // Invalidate beats a concurrent last-word fill, so that line stays empty.
            if (invalidate) begin
                valid_bits <= '0;
            end else if (refill_last) begin
                valid_bits[req_idx] <= 1'b1;
            end
            if (invalidate) begin
                rd_valid <= 1'b0;
            end else if (rd_en) begin
                rd_valid <= valid_bits[rd_idx];
            end
        end
    end

    // NOTE: every output of this block is defaulted first so no path infers a latch.
    always_comb begin
        next_state = state;
        ready_int  = 1'b0;
        case (state)
            IDLE: begin
                if (data_valid_reg) begin
                    if (data_wstrb_reg != '0) begin
                        next_state = WRITE;
                    end else if (hit) begin
                        ready_int = 1'b1;
                    end else begin
                        next_state = REFILL;
                    end
                end
            end
            REFILL: begin
                if (read_ready && (&word_cnt)) begin
                    next_state = REPLAY;
                end
            end
            REPLAY: begin
                next_state = IDLE;
            end
            WRITE: begin
                if (write_ready) begin
                    ready_int  = 1'b1;
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // A reset cycle aborts whatever is in flight, so it must not complete a request.
    assign data_ready  = ready_int && reset;
    assign data_rdata  = rd_data;

    assign read_valid  = (state == REFILL) && (word_cnt == '0);
    assign read_addr   = data_addr_reg[WADDR_W-1:WORD_OFF_W];

    assign write_valid = (state == WRITE);
    assign write_addr  = data_addr_reg;
    assign write_wdata = data_wdata_reg;
    assign write_wstrb = write_valid ? data_wstrb_reg : '0;

endmodule

// File: tb/tb_cache_memory_dm.sv
// Randomized bench for cache_memory_dm: a line-residency model plus a flat memory model
// predict every response; a monitor checks completions, back-end models check requests.
module tb_cache_memory_dm;

    logic        clk;
    logic        rst_stim, rst_be, reset;
    logic        inv_stim, inv_be, invalidate;
    logic        data_valid;
    logic [29:0] data_addr;
    logic        data_valid_reg;
    logic [29:0] data_addr_reg;
    logic [31:0] data_wdata_reg;
    logic [3:0]  data_wstrb_reg;
    logic [31:0] data_rdata;
    logic        data_ready;
    logic        read_valid;
    logic [27:0] read_addr;
    logic [31:0] read_rdata;
    logic        read_ready;
    logic        write_valid;
    logic [29:0] write_addr;
    logic [31:0] write_wdata;
    logic [3:0]  write_wstrb;
    logic        write_ready;

    assign reset      = rst_stim & rst_be;
    assign invalidate = inv_stim | inv_be;

    cache_memory_dm dut (
        .clk(clk), .reset(reset),
        .data_valid(data_valid), .data_addr(data_addr),
        .data_valid_reg(data_valid_reg), .data_addr_reg(data_addr_reg),
        .data_wdata_reg(data_wdata_reg), .data_wstrb_reg(data_wstrb_reg),
        .data_rdata(data_rdata), .data_ready(data_ready),
        .invalidate(invalidate),
        .read_valid(read_valid), .read_addr(read_addr),
        .read_rdata(read_rdata), .read_ready(read_ready),
        .write_valid(write_valid), .write_addr(write_addr),
        .write_wdata(write_wdata), .write_wstrb(write_wstrb),
        .write_ready(write_ready)
    );

    typedef struct {
        bit          is_write;
        logic [29:0] addr;
        logic [31:0] data;
        bit          hit;
        int          issue_cyc;
    } exp_t;

    typedef struct {
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } wr_t;

    exp_t        exp_q[$];
    wr_t         wr_q[$];
    logic [27:0] refill_q[$];

    bit          present[16];
    logic [23:0] ptag[16];
    logic [31:0] mem_m [logic [29:0]];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_refill_cyc = 0;
    int wr_ready_cyc = 0;
    bit abort_flag = 0;
    bit inv_flag = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic clear_present();
        for (int i = 0; i < 16; i++) present[i] = 1'b0;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst_stim = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_stim = 1'b1;
        clear_present();
    endtask

    task automatic do_invalidate();
        @(posedge clk); #1;
        inv_stim = 1'b1;
        @(posedge clk); #1;
        inv_stim = 1'b0;
        clear_present();
    endtask

    // One front-end request: address phase, then registered phase held until completion.
    task automatic issue(input bit wr, input logic [29:0] a, input logic [31:0] wd,
                         input logic [3:0] ws, input bit abort_it, input bit inv_it);
        exp_t        e;
        wr_t         x;
        logic [31:0] w;
        logic [3:0]  idx;
        logic [23:0] tg;
        bit          hit;
        bit          done;
        idx = a[5:2];
        tg  = a[29:6];
        hit = present[idx] && (ptag[idx] == tg);
        e.is_write = wr;
        e.addr     = a;
        e.hit      = hit;
        e.data     = mem_word(a);
        if (wr) begin
            w = mem_word(a);
            for (int b = 0; b < 4; b++) if (ws[b]) w[8*b +: 8] = wd[8*b +: 8];
            mem_m[a] = w;
            x.addr = a; x.wdata = wd; x.wstrb = ws;
            wr_q.push_back(x);
        end else if (!hit) begin
            refill_q.push_back(a[29:2]);
            abort_flag = abort_it;
            if (inv_it) begin
                refill_q.push_back(a[29:2]);
                inv_flag = 1'b1;
            end
        end
        @(posedge clk); #1;
        data_valid = 1'b1;
        data_addr  = a;
        @(posedge clk); #1;
        data_valid     = 1'($urandom_range(0, 1));
        data_addr      = 30'($urandom);
        data_valid_reg = 1'b1;
        data_addr_reg  = a;
        data_wdata_reg = wd;
        data_wstrb_reg = wr ? ws : 4'h0;
        e.issue_cyc = cyc;
        if (!abort_it) exp_q.push_back(e);
        done = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (data_ready || !reset) begin
                done = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        data_valid     = 1'b0;
        data_valid_reg = 1'b0;
        data_wstrb_reg = 4'h0;
        if (!done) begin
            check("req_timeout", data_ready, 1);
            exp_q.delete();
            wr_q.delete();
            refill_q.delete();
            apply_reset();
        end else if (abort_it) begin
            clear_present();
            repeat (4) @(posedge clk);
        end else if (!wr) begin
            if (inv_it) clear_present();
            present[idx] = 1'b1;
            ptag[idx]    = tg;
        end
    endtask

    // Completion monitor.
    always @(negedge clk) begin
        exp_t e;
        if (data_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_ready", data_ready, 0);
            end else begin
                e = exp_q.pop_front();
                if (e.is_write) begin
                    check("wr_latency", cyc, wr_ready_cyc);
                end else begin
                    check("rdata", data_rdata, e.data);
                    check("rd_latency", cyc, e.hit ? e.issue_cyc : last_refill_cyc + 2);
                end
            end
        end
    end

    // Back-end refill model.
    initial begin : backend_read
        logic [27:0] line;
        bit          aborted;
        read_ready = 1'b0;
        read_rdata = '0;
        rst_be     = 1'b1;
        inv_be     = 1'b0;
        forever begin
            @(negedge clk);
            if (read_valid && reset) begin
                line = read_addr;
                if (refill_q.size() == 0) check("unexpected_refill", read_valid, 0);
                else check("refill_addr", read_addr, refill_q.pop_front());
                aborted = 1'b0;
                for (int w = 0; w < 4; w++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                        read_ready = 1'b0;
                        read_rdata = $urandom;
                    end
                    @(posedge clk); #1;
                    read_ready = 1'b1;
                    read_rdata = mem_word({line, 2'(w)});
                    if (w == 2 && abort_flag) begin
                        rst_be     = 1'b0;
                        abort_flag = 1'b0;
                    end
                    if (w == 3) begin
                        last_refill_cyc = cyc;
                        if (inv_flag) begin
                            inv_be   = 1'b1;
                            inv_flag = 1'b0;
                        end
                    end
                    @(negedge clk);
                    if (!rst_be) begin
                        check("no_ready_in_reset", data_ready, 0);
                        aborted = 1'b1;
                        break;
                    end
                end
                @(posedge clk); #1;
                read_ready = 1'b0;
                inv_be     = 1'b0;
                rst_be     = 1'b1;
                if (!aborted) begin
                    @(negedge clk);
                    check("read_valid_drop", read_valid, 0);
                end
            end
        end
    end

    // Back-end write-through model.
    initial begin : backend_write
        wr_t x;
        write_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (write_valid && reset) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_write", write_valid, 0);
                end else begin
                    x = wr_q.pop_front();
                    check("write_addr", write_addr, x.addr);
                    check("write_wdata", write_wdata, x.wdata);
                    check("write_wstrb", write_wstrb, x.wstrb);
                end
                repeat ($urandom_range(0, 3)) begin
                    @(negedge clk);
                    check("write_valid_hold", write_valid, 1);
                end
                @(posedge clk); #1;
                write_ready  = 1'b1;
                wr_ready_cyc = cyc;
                @(posedge clk); #1;
                write_ready = 1'b0;
            end
        end
    end

    initial begin : stimulus
        int          r;
        bit          miss;
        logic [29:0] a;
        rst_stim       = 1'b0;
        inv_stim       = 1'b0;
        data_valid     = 1'b1;
        data_addr      = 30'h4;
        data_valid_reg = 1'b1;
        data_addr_reg  = 30'h4;
        data_wdata_reg = 32'h0;
        data_wstrb_reg = 4'hF;
        clear_present();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_data_ready", data_ready, 0);
        check("reset_read_valid", read_valid, 0);
        check("reset_write_valid", write_valid, 0);
        check("reset_write_wstrb", write_wstrb, 0);
        @(posedge clk); #1;
        rst_stim       = 1'b1;
        data_valid     = 1'b0;
        data_valid_reg = 1'b0;
        data_wstrb_reg = 4'h0;

        for (int i = 0; i < 4; i++) mem_m[30'h4 + 30'(i)] = 32'hA0 + 32'(i);
        issue(0, 30'h4,   32'h0,        4'h0, 0, 0);  // cold miss, line 1
        issue(0, 30'h4,   32'h0,        4'h0, 0, 0);  // hit
        issue(1, 30'h5,   32'hDEADBEEF, 4'h3, 0, 0);  // write hit, low half
        issue(0, 30'h5,   32'h0,        4'h0, 0, 0);
        issue(1, 30'h400, 32'h12345678, 4'hF, 0, 0);  // write miss, no allocate
        issue(0, 30'h400, 32'h0,        4'h0, 0, 0);
        do_invalidate();
        issue(0, 30'h4,   32'h0,        4'h0, 0, 0);
        issue(0, 30'h8,   32'h0,        4'h0, 0, 1);  // invalidate on last fill word
        issue(0, 30'h4,   32'h0,        4'h0, 1, 0);  // reset during third fill word
        issue(0, 30'h4,   32'h0,        4'h0, 0, 0);

        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 99);
            a = {24'($urandom_range(0, 2)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            if (r < 5) begin
                do_invalidate();
            end else if (r < 35) begin
                issue(1, a, $urandom, 4'($urandom_range(1, 15)), 0, 0);
            end else begin
                miss = !(present[a[5:2]] && (ptag[a[5:2]] == a[29:6]));
                issue(0, a, 32'h0, 4'h0, miss && (r >= 97), miss && (r >= 90) && (r < 97));
            end
        end

        repeat (5) @(negedge clk);
        check("queues_drained", exp_q.size() + wr_q.size() + refill_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
